// File: rtl/smoldvi_pkg.sv
// Shared definitions for the DVI timing path: FSM encoding, 640x480@60 default
// timing, and the TMDS control-period symbols selected by {C1,C0}.
package smoldvi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } dvi_state_e;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;
   localparam int DEF_W_CTR    = 11;

   localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
   localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
   localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
   localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

   function automatic logic [9:0] tmds_ctrl_sym(input logic c1, input logic c0);
      logic [9:0] sym;
      case ({c1, c0})
         2'b00:   sym = TMDS_CTRL_00;
         2'b01:   sym = TMDS_CTRL_01;
         2'b10:   sym = TMDS_CTRL_10;
         default: sym = TMDS_CTRL_11;
      endcase
      return sym;
   endfunction

endpackage

// File: rtl/dvi_timing_axis.sv
// One raster axis: wrapping counter with active/sync phase decode.
// Phase order is active, front porch, sync, back porch.
module dvi_timing_axis #(
   parameter int ACTIVE = 640,
   parameter int FRONT  = 16,
   parameter int SYNC   = 96,
   parameter int BACK   = 48,
   parameter int W      = 11
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] ctr_o,
   output logic         active_o,
   output logic         sync_o,
   output logic         wrap_o
);

   localparam int           TOTAL    = ACTIVE + FRONT + SYNC + BACK;
   localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
   localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FRONT);
   localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FRONT + SYNC);

   logic [W-1:0] ctr_q, ctr_d;

   always_comb begin
      ctr_d = ctr_q;
      if (clr_i) begin
         ctr_d = '0;
      end else if (inc_i) begin
         ctr_d = (ctr_q == LAST) ? '0 : ctr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) ctr_q <= '0;
      else          ctr_q <= ctr_d;
   end

   assign ctr_o    = ctr_q;
   assign active_o = (ctr_q < ACT_END);
   assign sync_o   = (ctr_q >= SYNC_BEG) && (ctr_q < SYNC_END);
   assign wrap_o   = inc_i && (ctr_q == LAST);

endmodule

// File: rtl/dvi_timing_ctrl.sv
// DVI raster timing and pixel scheduler: frame-aligned start/stop, two-stage
// output pipeline aligned to a 1-cycle-latency pixel source, sticky underflow.
//
//   state    | meaning
//   ST_IDLE  | counters held at 0, pipeline flushes to blanking
//   ST_RUN   | raster running, en high
//   ST_DRAIN | en dropped, finish current frame then go idle
module dvi_timing_ctrl
   import smoldvi_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FRONT    = DEF_H_FRONT,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BACK     = DEF_H_BACK,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FRONT    = DEF_V_FRONT,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BACK     = DEF_V_BACK,
   parameter bit H_SYNC_POL = 1'b0,
   parameter bit V_SYNC_POL = 1'b0,
   parameter int W_CTR      = DEF_W_CTR
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic             pix_req,
   output logic [W_CTR-1:0] pix_x,
   output logic [W_CTR-1:0] pix_y,
   input  logic [23:0]      rgb_in,
   input  logic             rgb_vld,
   output logic [23:0]      rgb_out,
   output logic             den,
   output logic             hsync,
   output logic             vsync,
   output logic             frame_start,
   output logic             running,
   output logic             underflow,
   input  logic             clr_underflow
);

   dvi_state_e       state_q, state_d;
   logic             run_w;
   logic [W_CTR-1:0] h_ctr, v_ctr;
   logic             h_act, h_sync_act, h_wrap;
   logic             v_act, v_sync_act, v_wrap;

   assign run_w = (state_q != ST_IDLE);

   dvi_timing_axis #(
      .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(W_CTR)
   ) u_h_axis (
      .clk_i(clk), .rst_n_i(rst_n), .clr_i(!run_w), .inc_i(run_w),
      .ctr_o(h_ctr), .active_o(h_act), .sync_o(h_sync_act), .wrap_o(h_wrap)
   );

   dvi_timing_axis #(
      .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(W_CTR)
   ) u_v_axis (
      .clk_i(clk), .rst_n_i(rst_n), .clr_i(!run_w), .inc_i(h_wrap),
      .ctr_o(v_ctr), .active_o(v_act), .sync_o(v_sync_act), .wrap_o(v_wrap)
   );

   // v_wrap fires only at the last pixel of the last line, so DRAIN exits on a frame edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (en) state_d = ST_RUN;
         ST_RUN:   if (!en) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (en)          state_d = ST_RUN;
            else if (v_wrap) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   assign pix_req = run_w && h_act && v_act;
   assign pix_x   = h_ctr;
   assign pix_y   = v_ctr;
   assign running = run_w;

   // Stage 1 holds the raster phase while the source produces the pixel.
   logic den1_q, den1_d, hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d;
   logic [23:0] rgb_d;
   logic        den_d, hsync_d, vsync_d, fs_d, underflow_d, uflow_set;

   always_comb begin
      den1_d      = pix_req;
      hs1_d       = run_w && h_sync_act;
      vs1_d       = run_w && v_sync_act;
      fs1_d       = run_w && (h_ctr == '0) && (v_ctr == '0);
      uflow_set   = den1_q && !rgb_vld;
      den_d       = den1_q;
      hsync_d     = hs1_q ? H_SYNC_POL : !H_SYNC_POL;
      vsync_d     = vs1_q ? V_SYNC_POL : !V_SYNC_POL;
      fs_d        = fs1_q;
      rgb_d       = (den1_q && rgb_vld) ? rgb_in : 24'h0;
      underflow_d = uflow_set ? 1'b1 : (clr_underflow ? 1'b0 : underflow);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         den1_q      <= 1'b0;
         hs1_q       <= 1'b0;
         vs1_q       <= 1'b0;
         fs1_q       <= 1'b0;
         den         <= 1'b0;
         hsync       <= !H_SYNC_POL;
         vsync       <= !V_SYNC_POL;
         frame_start <= 1'b0;
         rgb_out     <= 24'h0;
         underflow   <= 1'b0;
      end else begin
         den1_q      <= den1_d;
         hs1_q       <= hs1_d;
         vs1_q       <= vs1_d;
         fs1_q       <= fs1_d;
         den         <= den_d;
         hsync       <= hsync_d;
         vsync       <= vsync_d;
         frame_start <= fs_d;
         rgb_out     <= rgb_d;
         underflow   <= underflow_d;
      end
   end

endmodule

// File: doc/dvi_timing_ctrl.md
Name: dvi_timing_ctrl

Overview:
Video timing controller and pixel scheduler for the DVI output path, running in the pixel clock domain (clk_pix). It generates the horizontal and vertical raster counters and sync/data-enable for the TMDS encoders. It requests pixels from an upstream source with fixed 1-cycle latency and registers them into an encoder-aligned stream. Start/stop is always frame-aligned; source underflow is detected and reported.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (clk cycles)
H_SYNC, 96, hsync width
H_BACK, 48, horizontal back porch
V_ACTIVE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_POL, 0, hsync active level
V_SYNC_POL, 0, vsync active level
W_CTR, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run request; level-sensitive
pix_req  out  1  pixel request, combinational from registered counters
pix_x  out  W_CTR  active x for the current request (valid when pix_req=1)
pix_y  out  W_CTR  active y for the current request (valid when pix_req=1)
rgb_in  in  24  pixel data, valid 1 cycle after pix_req
rgb_vld  in  1  rgb_in valid qualifier
rgb_out  out  24  registered pixel to encoders
den  out  1  data enable to encoders
hsync  out  1  to TMDS ch0 C0
vsync  out  1  to TMDS ch0 C1
frame_start  out  1  1-cycle pulse aligned with the first active pixel of a frame
running  out  1  1 while state is RUN or DRAIN
underflow  out  1  sticky source-underflow flag
clr_underflow  in  1  clears underflow

Behaviour:
- Totals: H_TOTAL = sum of the four H_* parameters; V_TOTAL likewise for V_*.
- Line order: active, front porch, sync, back porch. Same order for frame lines.
- h_ctr wraps from H_TOTAL-1 to 0, and v_ctr increments on that wrap. v_ctr wraps from V_TOTAL-1 to 0.
- hsync is active when H_ACTIVE+H_FRONT <= h_ctr < H_ACTIVE+H_FRONT+H_SYNC.
- vsync is active by v_ctr over the whole line. It changes only at h_ctr=0.
- States:
  - IDLE: counters held at 0.
  - IDLE->RUN when en=1. Counters are (0,0) in the first RUN cycle.
  - RUN->DRAIN when en=0.
  - DRAIN->RUN when en=1 (no disturbance to the raster).
  - DRAIN->IDLE at counter state (H_TOTAL-1, V_TOTAL-1). Counters return to 0.
  - RUN is never left mid-frame.
- pix_req = (state != IDLE) && h_ctr < H_ACTIVE && v_ctr < V_ACTIVE. pix_x = h_ctr, pix_y = v_ctr.
- Pipeline: counter state at cycle n drives den/hsync/vsync/frame_start/rgb_out at cycle n+2 (two register stages).
  - Stage 1 captures rgb_in at n+1.
  - If stage-1 den=1 and rgb_vld=0: rgb_out <= 0 and underflow <= 1.
  - rgb_out <= 0 whenever den is 0.
  - rgb_vld outside a request is ignored.
- In IDLE, the pipeline stages load den=0 with syncs at their inactive level. Flush takes 2 cycles after entering IDLE.
- underflow: set and clr_underflow in the same cycle -> set wins.
- Reset values:
  - pix_req=0, den=0, rgb_out=0, frame_start=0, running=0, underflow=0.
  - hsync=!H_SYNC_POL, vsync=!V_SYNC_POL.
  - State IDLE, counters 0.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). The next frame starts from (0,0).

Decomposition:
- Shared package smoldvi_pkg holds:
  - state encoding constants;
  - default 640x480@60 timing constants;
  - TMDS control-symbol mapping constants.
- One sub-module, dvi_timing_axis: parameterised counter plus phase decode (active/sync) with a wrap output. Instantiated once for H and once for V, with V enabled by the H wrap.

Test Plan:
All tests use small timing: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), polarities 0.
1. Reset -> hsync=1, vsync=1, den=0, pix_req=0, running=0. en=1 -> pix_req=1 on the next cycle with (x,y)=(0,0); den=1 two cycles after that; frame_start=1 for one cycle with den.
2. Free-run one frame with rgb_vld=1 and rgb_in=x|y<<8 -> 12 den cycles, in 3 groups of 4. hsync low for 2 cycles per line starting 5 cycles after the line start. vsync low for exactly 8 cycles. rgb_out matches requests at latency 2.
3. Drop en mid-frame at (2,1) -> frame completes to (7,5), running falls, then den=0 and hsync/vsync=1 thereafter. Re-raise en in DRAIN at (0,4) -> no glitch, next frame starts seamlessly.
4. Force rgb_vld=0 for the request at (1,0) -> rgb_out=0 in that den cycle and underflow=1 (sticky). Assert set and clr_underflow together -> remains 1. clr_underflow alone -> 0.
5. Assert rst_n=0 at (3,2) with den=1 -> all outputs go to reset values asynchronously. Release with en=1 -> restart at (0,0).
6. Default parameters -> pix_req asserted 640×480 times per frame; frame period 800×525=420000 cycles.
